// File: rtl/clock_divider_prog_if.sv
// clock_divider_prog_if: control and status bundle for the programmable clock divider.
interface clock_divider_prog_if #(
  parameter int CHANNELS = 2,
  parameter int WIDTH = 8
);
  localparam int SEL_W = CHANNELS > 1 ? $clog2(CHANNELS) : 1;
  logic [CHANNELS-1:0] enable;
  logic div_wr;
  logic [SEL_W-1:0] div_sel;
  logic [WIDTH-1:0] div_value;
  logic [CHANNELS-1:0] clk_out;
  logic [CHANNELS-1:0] tick;
  logic [CHANNELS-1:0] pending;
  modport master(output enable, div_wr, div_sel, div_value, input clk_out, tick, pending);
  modport slave(input enable, div_wr, div_sel, div_value, output clk_out, tick, pending);
endinterface

// File: rtl/clock_divider_prog.sv
// clock_divider_prog: multi-channel programmable clock divider with glitch-free divisor updates.
module clock_divider_prog #(
  parameter int CHANNELS = 2,
  parameter int WIDTH = 8,
  parameter int RESET_DIV = 2
) (
  input logic clk_in,
  input logic rst,
  clock_divider_prog_if.slave bus
);
  localparam int SEL_W = CHANNELS > 1 ? $clog2(CHANNELS) : 1;
  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic [WIDTH-1:0] cnt_q, cnt_d, act_q, act_d, pval_q, pval_d;
    logic pend_q, pend_d, clk_q, clk_d, tick_q, tick_d;
    logic wr, stop, run, wrap;
    logic [WIDTH:0] half;
    assign wr = bus.div_wr && bus.div_sel == SEL_W'(c);
    assign stop = act_q == '0;
    assign run = bus.enable[c] && !stop;
    assign wrap = run && cnt_q == act_q - 1'b1;
    // a write landing on the wrap edge bypasses the staging register
    always_comb begin
      act_d = stop && pend_q ? pval_q : wrap && wr ? bus.div_value : wrap && pend_q ? pval_q : act_q;
      cnt_d = stop || wrap ? '0 : run ? cnt_q + 1'b1 : cnt_q;
      half = ({1'b0, act_d} + 1'b1) >> 1;
      clk_d = run || stop ? {1'b0, cnt_d} < half : clk_q;
      tick_d = wrap || (stop && pend_q && act_d != '0);
      pend_d = wrap ? 1'b0 : stop ? wr : pend_q | wr;
      pval_d = wr ? bus.div_value : pval_q;
    end
    always_ff @(posedge clk_in or posedge rst) begin
      if (rst) begin
        cnt_q <= '0;
        act_q <= WIDTH'(RESET_DIV);
        pval_q <= '0;
        pend_q <= 1'b0;
        clk_q <= 1'b0;
        tick_q <= 1'b0;
      end else begin
        cnt_q <= cnt_d;
        act_q <= act_d;
        pval_q <= pval_d;
        pend_q <= pend_d;
        clk_q <= clk_d;
        tick_q <= tick_d;
      end
    end
    assign bus.clk_out[c] = clk_q;
    assign bus.tick[c] = tick_q;
    assign bus.pending[c] = pend_q;
  end
endmodule

// File: tb/tb_clock_divider_prog.sv
// tb_clock_divider_prog: scoreboard bench for clock_divider_prog against a cycle model.
module tb_clock_divider_prog;
  localparam int CH = 3;
  localparam int W = 8;
  localparam int RD = 2;
  typedef struct packed {
    logic [CH-1:0] c;
    logic [CH-1:0] t;
    logic [CH-1:0] p;
  } exp_t;
  logic clk_in = 1'b0;
  logic rst = 1'b1;
  int n_tests = 0;
  int n_fail = 0;
  int m_cnt[CH], m_act[CH], m_pv[CH];
  bit m_pf[CH], m_clk[CH], m_tick[CH];
  exp_t sb[$];
  always #5 clk_in = ~clk_in;
  clock_divider_prog_if #(.CHANNELS(CH), .WIDTH(W)) bus ();
  clock_divider_prog #(.CHANNELS(CH), .WIDTH(W), .RESET_DIV(RD)) dut (
    .clk_in(clk_in),
    .rst(rst),
    .bus(bus)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic model_reset();
    for (int c = 0; c < CH; c++) begin
      m_cnt[c] = 0; m_act[c] = RD; m_pv[c] = 0;
      m_pf[c] = 0; m_clk[c] = 0; m_tick[c] = 0;
    end
  endtask
  task automatic model_step();
    bit w;
    int v;
    v = int'(bus.div_value);
    for (int c = 0; c < CH; c++) begin
      w = bus.div_wr && int'(bus.div_sel) == c;
      if (m_act[c] == 0) begin
        m_cnt[c] = 0;
        if (m_pf[c]) begin m_act[c] = m_pv[c]; m_pf[c] = 0; end
        m_tick[c] = m_act[c] != 0;
        m_clk[c] = m_act[c] != 0;
        if (w) begin m_pv[c] = v; m_pf[c] = 1; end
      end else if (!bus.enable[c]) begin
        m_tick[c] = 0;
        if (w) begin m_pv[c] = v; m_pf[c] = 1; end
      end else if (m_cnt[c] == m_act[c] - 1) begin
        m_cnt[c] = 0;
        m_tick[c] = 1;
        if (w) m_act[c] = v;
        else if (m_pf[c]) m_act[c] = m_pv[c];
        m_pf[c] = 0;
        m_clk[c] = 0 < (m_act[c] + 1) / 2;
      end else begin
        m_cnt[c]++;
        m_tick[c] = 0;
        if (w) begin m_pv[c] = v; m_pf[c] = 1; end
        m_clk[c] = m_cnt[c] < (m_act[c] + 1) / 2;
      end
    end
  endtask
  task automatic cyc();
    exp_t e;
    @(posedge clk_in);
    model_step();
    for (int c = 0; c < CH; c++) begin
      e.c[c] = m_clk[c]; e.t[c] = m_tick[c]; e.p[c] = m_pf[c];
    end
    sb.push_back(e);
    #1;
    e = sb.pop_front();
    chk("clk_out", 32'(bus.clk_out), 32'(e.c));
    chk("tick", 32'(bus.tick), 32'(e.t));
    chk("pending", 32'(bus.pending), 32'(e.p));
  endtask
  task automatic wr(input int sel, input int val);
    bus.div_wr = 1'b1;
    bus.div_sel = 2'(sel);
    bus.div_value = 8'(val);
    cyc();
    bus.div_wr = 1'b0;
  endtask
  task automatic period(input int ch, output int per, output int hi);
    int k;
    per = 0;
    hi = 0;
    for (k = 0; k < 300 && !bus.tick[ch]; k++) cyc();
    do begin
      hi += int'(bus.clk_out[ch]);
      cyc();
      per++;
    end while (!bus.tick[ch] && per < 300);
  endtask
  initial begin
    int per, hi, n, h;
    bus.enable = '1;
    bus.div_wr = 1'b0;
    bus.div_sel = '0;
    bus.div_value = '0;
    model_reset();
    repeat (2) @(posedge clk_in);
    #1;
    chk("rst_clk", 32'(bus.clk_out), 0);
    chk("rst_tick", 32'(bus.tick), 0);
    chk("rst_pend", 32'(bus.pending), 0);
    rst = 1'b0;
    cyc();
    chk("rel1_clk", 32'(bus.clk_out[0]), 0);
    cyc();
    chk("rel2_tick", 32'(bus.tick[0]), 1);
    chk("rel2_clk", 32'(bus.clk_out[0]), 1);
    repeat (4) cyc();
    for (int k = 0; k < 10 && m_cnt[0] != 0; k++) cyc();
    wr(0, 5);
    chk("d5_pend", 32'(bus.pending[0]), 1);
    period(0, per, hi);
    chk("d5_per", per, 5);
    chk("d5_hi", hi, 3);
    period(1, per, hi);
    chk("ch1_per", per, 2);
    chk("ch1_hi", hi, 1);
    wr(0, 1);
    period(0, per, hi);
    chk("d1_per", per, 1);
    chk("d1_hi", hi, 1);
    wr(0, 0);
    for (int k = 0; k < 10 && bus.pending[0]; k++) cyc();
    repeat (2) cyc();
    chk("d0_clk", 32'(bus.clk_out[0]), 0);
    chk("d0_tick", 32'(bus.tick[0]), 0);
    wr(0, 3);
    chk("stop_pend", 32'(bus.pending[0]), 1);
    cyc();
    chk("start_tick", 32'(bus.tick[0]), 1);
    chk("start_pend", 32'(bus.pending[0]), 0);
    period(0, per, hi);
    chk("d3_per", per, 3);
    chk("d3_hi", hi, 2);
    wr(1, 4);
    period(1, per, hi);
    chk("d4_per", per, 4);
    for (int k = 0; k < 10 && m_cnt[1] != 3; k++) cyc();
    wr(1, 6);
    chk("byp_tick", 32'(bus.tick[1]), 1);
    chk("byp_pend", 32'(bus.pending[1]), 0);
    wr(1, 7);
    chk("ovr_pend", 32'(bus.pending[1]), 1);
    n = 1;
    while (!bus.tick[1] && n < 50) begin cyc(); n++; end
    chk("byp_per6", n, 6);
    period(1, per, hi);
    chk("d7_per", per, 7);
    chk("d7_hi", hi, 4);
    wr(0, 8);
    period(0, per, hi);
    chk("d8_per", per, 8);
    repeat (3) cyc();
    h = m_cnt[0];
    bus.enable[0] = 1'b0;
    repeat (10) cyc();
    chk("hold_clk", 32'(bus.clk_out[0]), 1);
    chk("hold_tick", 32'(bus.tick[0]), 0);
    bus.enable[0] = 1'b1;
    cyc();
    n = 0;
    while (!bus.tick[0] && n < 50) begin cyc(); n++; end
    chk("resume_gap", n, 8 - h - 1);
    wr(3, 9);
    chk("sel3_pend", 32'(bus.pending), 0);
    period(1, per, hi);
    chk("sel3_ch1", per, 7);
    period(0, per, hi);
    chk("sel3_ch0", per, 8);
    cyc();
    wr(0, 4);
    chk("pre_rst_pend", 32'(bus.pending[0]), 1);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_clk", 32'(bus.clk_out), 0);
    chk("arst_tick", 32'(bus.tick), 0);
    chk("arst_pend", 32'(bus.pending), 0);
    model_reset();
    @(posedge clk_in);
    #1;
    rst = 1'b0;
    period(0, per, hi);
    chk("post_rst_per", per, 2);
    period(0, per, hi);
    chk("post_rst_per2", per, 2);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
